// File: rtl/fft_input_pairer_pkg.sv
// fft_input_pairer_pkg: shared sample type and pair-index helper for the FFT input pairer.
package fft_input_pairer_pkg;

    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } complex_product_t;

    function automatic int pair_hi_idx(input int k, input int n);
        return k + n / 2;
    endfunction

endpackage

// File: rtl/fft_input_pairer_bank.sv
// fft_pair_bank: one N-entry sample bank, single write port, dual-index read of (k, k+N/2).
module fft_pair_bank
    import fft_input_pairer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [$clog2(N)-1:0]   wr_idx,
    input  complex_product_t       wr_data,
    input  logic [$clog2(N)-2:0]   rd_idx,
    output complex_product_t       rd_lo,
    output complex_product_t       rd_hi
);
    localparam int LW = $clog2(N);

    complex_product_t mem [N];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_idx] <= wr_data;

    assign rd_lo = mem[{1'b0, rd_idx}];
    assign rd_hi = mem[LW'(pair_hi_idx(int'(rd_idx), N))];
endmodule

// File: rtl/fft_input_pairer.sv
// fft_input_pairer: buffers N-sample symbols in ping-pong banks and replays them as radix-2 DIF pairs.
// Define FFT_PAIR_CP_STRIP_EN to drop CP_LEN cyclic-prefix samples at the head of every frame.
module fft_input_pairer
    import fft_input_pairer_pkg::*;
#(
    parameter int N      = 8,
    parameter int CP_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  complex_product_t in_sample,
    output logic             in_ready,
    input  logic             out_stall,
    output complex_product_t data_0,
    output complex_product_t data_1,
    output logic             enable,
    output logic             sym_first,
    output logic             sym_last,
    output logic             overflow
);
    localparam int LW = $clog2(N);
    localparam int KW = LW - 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("N must be a power of two >= 4");
    end
    if (CP_LEN < 0 || CP_LEN >= N) begin : g_bad_cp
        $error("CP_LEN must be in [0, N)");
    end

    logic [1:0]       bank_full;
    logic             wr_bank;
    logic             rd_bank;
    logic [LW-1:0]    wr_cnt;
    logic [KW-1:0]    rd_cnt;
    logic [0:0]       state;
    logic             accept;
    logic             store;
    logic             wr_done;
    logic             go;
    logic             rd_done;
    logic [1:0]       set_full;
    logic [1:0]       clr_full;
    complex_product_t lo [2];
    complex_product_t hi [2];

    assign in_ready = !bank_full[wr_bank];
    assign accept   = in_valid && in_ready;

`ifdef FFT_PAIR_CP_STRIP_EN
    logic [LW-1:0] cp_cnt;

    assign store = accept && (cp_cnt == LW'(CP_LEN));

    always_ff @(posedge clk or negedge reset)
        if (!reset) cp_cnt <= '0;
        else if (wr_done) cp_cnt <= '0;
        else if (accept && !store) cp_cnt <= cp_cnt + 1'b1;
`else
    assign store = accept;
`endif

    assign wr_done  = store && (wr_cnt == LW'(N - 1));
    // IDLE with a full bank emits pair 0 on the same edge, giving one-cycle latency
    assign go       = (state == EMIT || bank_full[rd_bank]) && !out_stall;
    assign rd_done  = go && (rd_cnt == KW'(N / 2 - 1));
    assign set_full = wr_done ? 2'b01 << wr_bank : 2'b00;
    assign clr_full = rd_done ? 2'b01 << rd_bank : 2'b00;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_pair_bank #(.N(N)) u_bank (
            .clk     (clk),
            .wr_en   (store && wr_bank == 1'(b)),
            .wr_idx  (wr_cnt),
            .wr_data (in_sample),
            .rd_idx  (rd_cnt),
            .rd_lo   (lo[b]),
            .rd_hi   (hi[b])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            state     <= IDLE;
            data_0    <= '0;
            data_1    <= '0;
            enable    <= 1'b0;
            sym_first <= 1'b0;
            sym_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            bank_full <= (bank_full | set_full) & ~clr_full;
            if (store) wr_cnt <= wr_cnt + 1'b1;
            if (wr_done) wr_bank <= !wr_bank;
            if (go) begin
                data_0 <= lo[rd_bank];
                data_1 <= hi[rd_bank];
                rd_cnt <= rd_cnt + 1'b1;
            end
            enable    <= go;
            sym_first <= go && (rd_cnt == '0);
            sym_last  <= rd_done;
            if (rd_done) rd_bank <= !rd_bank;
            state <= rd_done ? (bank_full[!rd_bank] ? EMIT : IDLE) : (go ? EMIT : state);
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_input_pairer.sv
// tb_fft_input_pairer: randomized and directed checks against a queue-based symbol/pair model.
module tb_fft_input_pairer;
    import fft_input_pairer_pkg::*;

    localparam int N = 8;
`ifdef FFT_PAIR_CP_STRIP_EN
    localparam int CPL = 2;
`else
    localparam int CPL = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    complex_product_t in_sample = '0;
    logic             in_ready;
    logic             out_stall = 1'b0;
    complex_product_t data_0;
    complex_product_t data_1;
    logic             enable;
    logic             sym_first;
    logic             sym_last;
    logic             overflow;

    fft_input_pairer #(.N(N), .CP_LEN(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .in_ready  (in_ready),
        .out_stall (out_stall),
        .data_0    (data_0),
        .data_1    (data_1),
        .enable    (enable),
        .sym_first (sym_first),
        .sym_last  (sym_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        complex_product_t d0;
        complex_product_t d1;
        logic             first;
        logic             last;
    } pair_t;

    pair_t            exp_q [$];
    complex_product_t sym_q [$];
    int               fpos;
    logic             exp_en;
    logic             exp_first;
    logic             exp_last;
    logic             exp_ovf;
    complex_product_t last0;
    complex_product_t last1;
    int               total = 0;
    int               bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic complex_product_t mk(input int r);
        complex_product_t c;
        c.re = 16'(r);
        c.im = '0;
        return c;
    endfunction

    // symbols still holding a bank: complete symbols with any pair not yet emitted
    function automatic int pending();
        return (exp_q.size() + N / 2 - 1) / (N / 2);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        sym_q.delete();
        fpos = 0;
        exp_en = 0;
        exp_first = 0;
        exp_last = 0;
        exp_ovf = 0;
        last0 = '0;
        last1 = '0;
    endtask

    task automatic model_edge();
        pair_t p;
        logic  rdy;
        rdy = pending() < 2;
        exp_en = 0;
        exp_first = 0;
        exp_last = 0;
        if (exp_q.size() > 0 && !out_stall) begin
            p = exp_q.pop_front();
            exp_en = 1;
            exp_first = p.first;
            exp_last = p.last;
            last0 = p.d0;
            last1 = p.d1;
        end
        if (in_valid && !rdy) exp_ovf = 1;
        if (in_valid && rdy) begin
            if (fpos >= CPL) sym_q.push_back(in_sample);
            fpos = (fpos == CPL + N - 1) ? 0 : fpos + 1;
            if (sym_q.size() == N) begin
                for (int k = 0; k < N / 2; k++)
                    exp_q.push_back('{sym_q[k], sym_q[k + N / 2], k == 0, k == N / 2 - 1});
                sym_q.delete();
            end
        end
    endtask

    task automatic compare();
        check("enable", 64'(enable), 64'(exp_en));
        check("sym_first", 64'(sym_first), 64'(exp_first));
        check("sym_last", 64'(sym_last), 64'(exp_last));
        check("data_0", 64'(data_0), 64'(last0));
        check("data_1", 64'(data_1), 64'(last1));
        check("in_ready", 64'(in_ready), 64'(pending() < 2));
        check("overflow", 64'(overflow), 64'(exp_ovf));
    endtask

    task automatic cycle(input logic v, input complex_product_t s, input logic st);
        in_valid = v;
        in_sample = s;
        out_stall = st;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic send_sym(input int base);
        for (int j = 0; j < CPL; j++) cycle(1'b1, mk(base + N - CPL + j), 1'b0);
        for (int j = 0; j < N; j++) cycle(1'b1, mk(base + j), 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) cycle(1'b0, '0, 1'b0);
        check("drain", 64'(exp_q.size()), 64'd0);
        cycle(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_stall = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_enable", 64'(enable), 64'd0);
        check("rst_data_0", 64'(data_0), 64'd0);
        check("rst_data_1", 64'(data_1), 64'd0);
        check("rst_first_last", 64'({sym_first, sym_last}), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        compare();

        send_sym(0);
        for (int k = 0; k < N / 2; k++) begin
            cycle(1'b0, '0, 1'b0);
            check("pair_en", 64'(enable), 64'd1);
            check("pair_lo", 64'(data_0.re), 64'(k));
            check("pair_hi", 64'(data_1.re), 64'(k + N / 2));
        end
        cycle(1'b0, '0, 1'b0);
        check("after_sym_en", 64'(enable), 64'd0);

        send_sym(0);
        send_sym(10);
        drain();

        send_sym(0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("stall_en", 64'(enable), 64'd0);
        cycle(1'b0, '0, 1'b1);
        check("stall_hold", 64'(data_0.re), 64'd0);
        drain();

        for (int i = 0; i < 3 * (N + CPL); i++) cycle(1'b1, mk(30 + i), 1'b1);
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_ovf", 64'(overflow), 64'd1);
        drain();
        check("ovf_sticky", 64'(overflow), 64'd1);

        send_sym(0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        do_reset();
        compare();
        send_sym(20);
        cycle(1'b0, '0, 1'b0);
        check("post_rst_lo", 64'(data_0.re), 64'd20);
        check("post_rst_hi", 64'(data_1.re), 64'd24);
        drain();

        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, complex_product_t'($urandom), $urandom_range(0, 3) == 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_input_pairer.md
Name: fft_input_pairer

Overview:
- Upstream feeder for fft_8_rad2.
- Accepts a serial stream of complex time-domain samples, one per cycle, under a valid/ready handshake, and buffers one OFDM symbol of N samples.
- Replays each buffered symbol as radix-2 DIF input pairs (x[k], x[k+N/2]) for k = 0..N/2-1 on the FFT's data_0/data_1/enable inputs.
- Ping-pong banks let the next symbol fill while the current one is emitted.

Parameters:
- N, 8, FFT size; power of two, >= 4.
- CP_LEN, 2, cyclic-prefix samples per symbol; used only when FFT_PAIR_CP_STRIP_EN is defined; 0 <= CP_LEN < N.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserted at 0.
- in_valid  input  1  in_sample is valid this cycle.
- in_sample  input  complex_product_t  serial time-domain sample.
- in_ready  output  1  block can accept in_sample this cycle.
- out_stall  input  1  downstream requests a pause of pair emission.
- data_0  output  complex_product_t  x[k]; to FFT data_0.
- data_1  output  complex_product_t  x[k+N/2]; to FFT data_1.
- enable  output  1  data_0/data_1 valid; to FFT enable.
- sym_first  output  1  pair k = 0 of a symbol; qualified by enable.
- sym_last  output  1  pair k = N/2-1 of a symbol; qualified by enable.
- overflow  output  1  sticky: in_valid was seen while in_ready = 0.

Behaviour:
- Storage: two banks of N complex_product_t entries, bank_full[1:0], wr_bank, rd_bank, wr_cnt (log2 N bits), rd_cnt (log2(N/2) bits).
- Reset (reset = 0, asynchronous):
  - all counters, bank pointers and bank_full clear to 0; read FSM goes to IDLE;
  - data_0, data_1, enable, sym_first, sym_last, overflow all 0;
  - in_ready = 1.
  - Reset mid-symbol discards all buffered data.
- Write side:
  - in_ready = !bank_full[wr_bank], combinational from registers.
  - On in_valid && in_ready: bank[wr_bank][wr_cnt] <= in_sample, wr_cnt++.
  - When wr_cnt == N-1 is accepted: bank_full[wr_bank] <= 1, wr_bank flips, wr_cnt <= 0.
  - in_valid while in_ready = 0: sample dropped, overflow <= 1 (sticky until reset).
- Read FSM:
  - IDLE:
    - if bank_full[rd_bank], go to EMIT with rd_cnt = 0.
    - The full flag is registered, so the first pair is presented the cycle after the N-th sample is accepted.
  - EMIT, out_stall = 0:
    - registered outputs data_0 <= bank[rd_bank][rd_cnt], data_1 <= bank[rd_bank][rd_cnt+N/2], enable <= 1;
    - sym_first <= (rd_cnt == 0), sym_last <= (rd_cnt == N/2-1); rd_cnt++.
  - EMIT, out_stall = 1:
    - enable <= 0, sym_first/sym_last <= 0; data_0/data_1 hold their values; rd_cnt holds.
  - EMIT at rd_cnt == N/2-1 (not stalled):
    - bank_full[rd_bank] <= 0, rd_bank flips.
    - If the other bank's full flag is 1 that cycle, stay in EMIT with no gap (back-to-back symbols); else go to IDLE.
  - In IDLE: enable = 0; data_0/data_1 hold their last values.
- Latency: last input sample accepted at edge t -> enable = 1 with pair 0 after edge t+1. A symbol occupies exactly N/2 enabled cycles when out_stall = 0.
- Simultaneous events:
  - Write completing one bank and read releasing the other in the same cycle are both honoured.
  - A write into a bank in the same cycle that bank is released is not possible: that bank is full, so in_ready = 0 for it.
- Ordering: symbols are emitted strictly in arrival order. Sample order within a symbol follows the write index, wrapping at N.

Optional Feature:
- FFT_PAIR_CP_STRIP_EN defined:
  - each input frame is CP_LEN + N samples;
  - a cp_cnt discards the first CP_LEN accepted samples of each frame (in_ready still 1, no bank write);
  - the following N samples are stored as above; cp_cnt rearms after wr_cnt wraps.
- Not defined: CP_LEN is ignored, no cp_cnt logic exists, and every accepted sample is stored.

Decomposition:
- complex_product_t stays in the shared headers package; no new package types.
- Add to the shared package: function pair_hi_idx(k, N) returning k + N/2.
- One natural sub-module, fft_pair_bank: a single N-entry bank with one write port and a dual-index read port (k, k+N/2). Instantiate it twice.

Test Plan:
- N=8, samples r = 0..7 (i = 0) with in_valid held high -> one cycle after sample 7:
  - pairs (0,4), (1,5), (2,6), (3,7) on 4 consecutive enabled cycles;
  - sym_first on (0,4), sym_last on (3,7);
  - then enable = 0.
- Two symbols back-to-back (r = 0..7, then 10..17, no gaps) -> pairs (0,4)..(3,7), idle, then (10,14)..(13,17). in_ready stays 1 throughout.
- out_stall = 1 for 2 cycles during pair 1 -> enable low for 2 cycles with data held; then (1,5), (2,6), (3,7) resume; no pair lost or duplicated.
- Hold out_stall = 1 while 3 symbols are offered -> in_ready drops after 16 accepted samples. A forced in_valid during that time sets overflow = 1, and overflow stays 1.
- Assert reset = 0 mid-emission after pair (1,5) -> all outputs 0 immediately (asynchronous). After release, a new symbol 20..27 emits (20,24)..(23,27).
- FFT_PAIR_CP_STRIP_EN with CP_LEN = 2, frame r = 6, 7, 0..7 -> emitted pairs (0,4)..(3,7); the CP samples 6, 7 do not appear.
